// File: rtl/shiftreg_pkg.sv
// Shared constants for the framed shift register: FSM encoding and shift-direction modes.
package shiftreg_pkg;

  typedef logic state_t;

  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_ACTIVE = 1'b1;

  localparam logic MODE_MSB = 1'b0;
  localparam logic MODE_LSB = 1'b1;

endpackage : shiftreg_pkg

// File: rtl/framed_shiftregister_if.sv
// Control and data bundle of the framed shift register; master drives, slave is the register.
interface framed_shiftregister_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) ();

  logic             peripheralClkEdge;
  logic             parallelLoad;
  logic             frameStart;
  logic             lsbFirst;
  logic [WIDTH-1:0] parallelDataIn;
  logic             serialDataIn;
  logic [WIDTH-1:0] parallelDataOut;
  logic             serialDataOut;
  logic [CNTW-1:0]  bitCount;
  logic             frameDone;
  logic             busy;

  modport master (
    output peripheralClkEdge, parallelLoad, frameStart, lsbFirst,
           parallelDataIn, serialDataIn,
    input  parallelDataOut, serialDataOut, bitCount, frameDone, busy
  );

  modport slave (
    input  peripheralClkEdge, parallelLoad, frameStart, lsbFirst,
           parallelDataIn, serialDataIn,
    output parallelDataOut, serialDataOut, bitCount, frameDone, busy
  );

endinterface : framed_shiftregister_if

// File: rtl/bitcounter.sv
// Per-frame shift counter: synchronous clear, increment, and a flag that the next increment
// completes the frame.
module bitcounter #(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clear,
  input  logic            i_inc,
  output logic [CNTW-1:0] o_count,
  output logic            o_terminal
);

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  logic [CNTW-1:0] r_count;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNTW'(1);
    end
  end

  assign o_count    = r_count;
  assign o_terminal = (r_count == LAST);

endmodule : bitcounter

// File: rtl/framed_shiftregister.sv
// Bidirectional shift register with frame tracking: load/start opens a frame, the WIDTH-th shift
// closes it with a one-cycle frameDone pulse.
module framed_shiftregister
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  framed_shiftregister_if.slave  bus
);

  logic [WIDTH-1:0] r_data;
  logic             r_mode;
  state_t           r_state;
  logic             r_frame_done;

  logic             w_start;
  logic             w_shift;
  logic             w_count_inc;
  logic             w_terminal;
  logic             w_last_shift;
  logic [CNTW-1:0]  w_count;
  logic [WIDTH-1:0] w_shifted;

  // A load or frame start pre-empts the edge in the same cycle, so no shift happens then.
  assign w_start      = bus.parallelLoad | bus.frameStart;
  assign w_shift      = bus.peripheralClkEdge & ~w_start;
  assign w_count_inc  = w_shift & (r_state == ST_ACTIVE);
  assign w_last_shift = w_count_inc & w_terminal;

  assign w_shifted = (r_mode == MODE_LSB) ? {bus.serialDataIn, r_data[WIDTH-1:1]}
                                          : {r_data[WIDTH-2:0], bus.serialDataIn};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_mode <= MODE_MSB;
    end else if (bus.parallelLoad) begin
      r_data <= bus.parallelDataIn;
      r_mode <= bus.lsbFirst;
    end else if (bus.frameStart) begin
      r_mode <= bus.lsbFirst;
    end else if (bus.peripheralClkEdge) begin
      r_data <= w_shifted;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_shift;
      if (w_start) begin
        r_state <= ST_ACTIVE;
      end else if (w_last_shift) begin
        r_state <= ST_IDLE;
      end
    end
  end

  bitcounter #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_bitcounter (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_start),
    .i_inc      (w_count_inc),
    .o_count    (w_count),
    .o_terminal (w_terminal)
  );

  assign bus.parallelDataOut = r_data;
  assign bus.serialDataOut   = (r_mode == MODE_LSB) ? r_data[0] : r_data[WIDTH-1];
  assign bus.bitCount        = w_count;
  assign bus.frameDone       = r_frame_done;
  assign bus.busy            = (r_state == ST_ACTIVE);

endmodule : framed_shiftregister

// File: tb/tb_framed_shiftregister.sv
// Directed, table-driven bench for framed_shiftregister at WIDTH=8.
module tb_framed_shiftregister;

  localparam int WIDTH = 8;
  localparam int CNTW  = 4;

  typedef struct {
    logic       ld;
    logic       fs;
    logic       ed;
    logic       lsb;
    logic [7:0] pd;
    logic       sin;
    logic [7:0] pout;
    logic       sout;
    logic [3:0] cnt;
    logic       done;
    logic       busy;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  framed_shiftregister_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  framed_shiftregister #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] pout, input logic sout,
                            input logic [3:0] cnt, input logic done, input logic busy);
    check({tag, ".pout"}, 32'(bus.parallelDataOut), 32'(pout));
    check({tag, ".sout"}, 32'(bus.serialDataOut),   32'(sout));
    check({tag, ".cnt"},  32'(bus.bitCount),        32'(cnt));
    check({tag, ".done"}, 32'(bus.frameDone),       32'(done));
    check({tag, ".busy"}, 32'(bus.busy),            32'(busy));
  endtask

  task automatic drive(input logic ld, input logic fs, input logic ed, input logic lsb,
                       input logic [7:0] pd, input logic sin);
    bus.parallelLoad      = ld;
    bus.frameStart        = fs;
    bus.peripheralClkEdge = ed;
    bus.lsbFirst          = lsb;
    bus.parallelDataIn    = pd;
    bus.serialDataIn      = sin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic ld, input logic fs, input logic ed, input logic lsb,
                              input logic [7:0] pd, input logic sin, input logic [7:0] pout,
                              input logic sout, input logic [3:0] cnt, input logic done,
                              input logic busy);
    vec_t v;
    v.ld = ld; v.fs = fs; v.ed = ed; v.lsb = lsb; v.pd = pd; v.sin = sin;
    v.pout = pout; v.sout = sout; v.cnt = cnt; v.done = done; v.busy = busy;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(0, 0, 0, 0, 8'h00, 0);

    // Fields: load, fstart, edge, lsbFirst, pdata, sin | pout, sout, bitCount, frameDone, busy
    // IDLE shift straight out of reset: data moves, count stays 0
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h01,0,0,0,0));
    // Load 0x3B LSB-first, shift zeros; live lsbFirst dropped to 0 mid-frame
    vecs.push_back(mk(1,0,0,1,8'h3B,0, 8'h3B,1,0,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,0, 8'h1D,1,1,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,0, 8'h0E,0,2,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h07,1,3,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,0, 8'h03,1,4,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h01,1,5,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,0, 8'h00,0,6,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,0, 8'h00,0,7,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,0, 8'h00,0,8,1,0));
    vecs.push_back(mk(0,0,0,0,8'h00,0, 8'h00,0,8,0,0));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h80,0,8,0,0));
    // Load 0x92 MSB-first, shift ones; live lsbFirst raised mid-frame
    vecs.push_back(mk(1,0,0,0,8'h92,0, 8'h92,1,0,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h25,0,1,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h4B,0,2,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,1, 8'h97,1,3,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,1, 8'h2F,0,4,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h5F,0,5,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'hBF,1,6,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h7F,0,7,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'hFF,1,8,1,0));
    // frameStart LSB-first on 0xFF, receive 1,0,0,1,0,0,1,0 -> 0x49
    vecs.push_back(mk(0,1,0,1,8'h00,0, 8'hFF,1,0,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'hFF,1,1,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,0, 8'h7F,1,2,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,0, 8'h3F,1,3,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h9F,1,4,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,0, 8'h4F,1,5,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,0, 8'h27,1,6,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h93,1,7,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,0, 8'h49,1,8,1,0));
    vecs.push_back(mk(0,0,0,0,8'h00,0, 8'h49,1,8,0,0));
    // Load coincident with edge (no shift), 4 shifts, reload restarts the frame
    vecs.push_back(mk(1,0,1,0,8'hA5,1, 8'hA5,1,0,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h4A,0,1,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h94,1,2,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h28,0,3,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h50,0,4,0,1));
    vecs.push_back(mk(1,0,1,1,8'hA5,1, 8'hA5,1,0,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h52,0,1,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h29,1,2,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h14,0,3,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h0A,0,4,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h05,1,5,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h02,0,6,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h01,1,7,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h00,0,8,1,0));
    vecs.push_back(mk(0,0,0,0,8'h00,0, 8'h00,0,8,0,0));
    // Load on the WIDTH-th edge wins; then frameStart aborts an active frame
    vecs.push_back(mk(0,1,0,0,8'h00,0, 8'h00,0,0,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h01,0,1,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h03,0,2,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h07,0,3,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h0F,0,4,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h1F,0,5,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h3F,0,6,0,1));
    vecs.push_back(mk(0,0,1,0,8'h00,1, 8'h7F,0,7,0,1));
    vecs.push_back(mk(1,0,1,1,8'h3C,1, 8'h3C,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,8'h00,0, 8'h3C,0,0,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h1E,0,1,0,1));
    vecs.push_back(mk(0,0,1,1,8'h00,0, 8'h0F,1,2,0,1));
    vecs.push_back(mk(0,1,1,0,8'h00,1, 8'h0F,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,8'h00,0, 8'h0F,0,0,0,1));

    tick();
    tick();
    check_outs("reset", 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ld, vecs[i].fs, vecs[i].ed, vecs[i].lsb, vecs[i].pd, vecs[i].sin);
      tick();
      drive(0, 0, 0, 0, 8'h00, 0);
      check_outs($sformatf("v%0d", i), vecs[i].pout, vecs[i].sout, vecs[i].cnt,
                 vecs[i].done, vecs[i].busy);
    end

    // Asynchronous reset three shifts into a frame, asserted between clock edges
    drive(1, 0, 0, 1, 8'h3B, 0);
    tick();
    drive(0, 0, 1, 1, 8'h00, 0);
    tick();
    tick();
    tick();
    check_outs("prerst", 8'h07, 1'b1, 4'd3, 1'b0, 1'b1);
    drive(0, 0, 0, 0, 8'h00, 0);
    #2;
    reset = 1'b1;
    #1;
    check_outs("midrst", 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    drive(0, 0, 1, 1, 8'h00, 1);
    tick();
    check_outs("idle1", 8'h01, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    check_outs("idle2", 8'h03, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 8'h00, 0);
    tick();
    check_outs("idle3", 8'h03, 1'b0, 4'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_framed_shiftregister

// File: doc/framed_shiftregister.md
FRAMED_SHIFTREGISTER -- requirements
Module: framed_shiftregister

Interface
REQ-001 Parameter WIDTH, default 8, shift register length in bits (WIDTH >= 2).
REQ-002 Parameter CNTW, default $clog2(WIDTH+1), bit-counter width.
REQ-003 Port clk  input  1  FPGA clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port peripheralClkEdge  input  1  shift enable, single-cycle edge indicator.
REQ-006 Port parallelLoad  input  1  loads parallelDataIn, starts a frame.
REQ-007 Port frameStart  input  1  starts a receive frame without loading data.
REQ-008 Port lsbFirst  input  1  mode: 1 = LSB first, shift right; 0 = MSB first, shift left.
REQ-009 Port parallelDataIn  input  WIDTH  parallel load data.
REQ-010 Port serialDataIn  input  1  serial input bit.
REQ-011 Port parallelDataOut  output  WIDTH  register contents.
REQ-012 Port serialDataOut  output  1  outgoing bit: reg[0] if latched mode is LSB-first, else reg[WIDTH-1].
REQ-013 Port bitCount  output  CNTW  bits shifted in the current frame.
REQ-014 Port frameDone  output  1  one-cycle pulse after the WIDTH-th shift of a frame.
REQ-015 Port busy  output  1  high while state is ACTIVE.

Function
REQ-016 Priority per cycle: reset > parallelLoad > frameStart > peripheralClkEdge > hold.
REQ-017 parallelLoad: reg <= parallelDataIn; mode <= lsbFirst; bitCount <= 0; state <= ACTIVE; no shift that cycle.
REQ-018 frameStart (no load): reg unchanged; mode <= lsbFirst; bitCount <= 0; state <= ACTIVE.
REQ-019 Shift, LSB mode: reg <= {serialDataIn, reg[WIDTH-1:1]}.
REQ-020 Shift, MSB mode: reg <= {reg[WIDTH-2:0], serialDataIn}.
REQ-021 Shifting occurs on every peripheralClkEdge in both states; mode is the latched value, never the live lsbFirst.
REQ-022 State machine IDLE/ACTIVE: IDLE -> ACTIVE on load or frameStart; ACTIVE -> IDLE on the WIDTH-th shift.
REQ-023 In ACTIVE, each shift increments bitCount; on the shift taking bitCount to WIDTH, the next cycle shows frameDone=1, busy=0, bitCount=WIDTH.
REQ-024 bitCount holds WIDTH in IDLE until the next load or frameStart; IDLE shifts never change bitCount and never pulse frameDone.
REQ-025 frameDone is registered, high exactly one cycle per completed frame.
REQ-026 Load or frameStart in ACTIVE restarts the frame: count 0, no frameDone for the aborted frame.
REQ-027 Load coincident with the WIDTH-th edge: load wins, no shift, no frameDone.
REQ-028 parallelDataOut and serialDataOut are combinational from the register and latched mode, with no added latency.

Reset
REQ-029 Asserting reset immediately sets reg=0, mode=0 (MSB first), bitCount=0, state=IDLE, frameDone=0, busy=0, serialDataOut=0.
REQ-030 Reset asserted mid-frame aborts the frame without a frameDone pulse; the first edge after deassertion obeys REQ-016.

Structure
REQ-031 Shared package shiftreg_pkg holds the IDLE/ACTIVE state encoding and the MODE_MSB=0/MODE_LSB=1 constants.
REQ-032 One sub-module, bitcounter (clear, increment, terminal-count compare against WIDTH), is instantiated once.

Verification
REQ-033 WIDTH=8, frameStart with lsbFirst=1, then 8 shifts of serial bits 1,0,0,1,0,0,1,0 -> parallelDataOut=0x49, frameDone pulses once, bitCount=8.
REQ-034 Load 0x3B with lsbFirst=1, then 8 shifts with serialDataIn=0 -> serialDataOut before each shift is 1,1,0,1,1,1,0,0; parallelDataOut sequence after shifts is 0x1D,0x0E,0x07,0x03,0x01,0x00,0x00,0x00.
REQ-035 Load 0x92 with lsbFirst=0 -> serialDataOut sequence is 1,0,0,1,0,0,1,0; after 8 shifts of serialDataIn=1, parallelDataOut=0xFF.
REQ-036 Load, 4 shifts, reload 0xA5 -> bitCount=0, busy=1; frameDone appears only 8 shifts after the reload.
REQ-037 Reset asserted after 3 shifts, between clock edges -> all outputs are 0 immediately; later shifts in IDLE change the data but leave bitCount=0 and frameDone=0.
REQ-038 Load coincident with peripheralClkEdge, and lsbFirst toggled mid-frame -> loaded value is unshifted and shift direction follows the latched mode.
